vq_accum_ram: RTL and testbench

Parametrised single-clock codebook/accumulator RAM for the VQ classification and training path. It supports plain overwrite writes and signed saturating read-modify-write accumulate writes (mem[a] += d), so the LBG training loop can sum vectors per codeword. It also provides a hardware clear sweep and full read-after-write forwarding. It replaces the fixed 24x256 classify RAM, and every classify/train consumer reads through it.

---
 rtl/vq_accum_ram.sv | 138 +++++++++++++
 tb/tb_vq_accum_ram.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vq_accum_ram.sv
// Codebook/accumulator RAM: overwrite or signed saturating accumulate writes through a
// two-stage read-modify-write pipeline, with full forwarding and a hardware clear sweep.
module vq_accum_ram #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 8,
    parameter int OUTPUT_REG = 0,
    parameter int CLR_ON_RST = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  wr_acc,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  clr_start,
    output logic                  ready,
    output logic                  busy,
    output logic                  ovf
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Handshake: a request is taken on any rising edge where its enable and ready are both
    // high; there is no back-pressure queue, so requests seen while busy are simply dropped.

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    s1_valid;
    logic                    s1_acc;
    logic [ADDR_WIDTH-1:0]   s1_addr;
    logic [DATA_WIDTH-1:0]   s1_data;
    logic [DATA_WIDTH-1:0]   s1_old;
    logic [DATA_WIDTH:0]     s1_sum;
    logic                    s1_clamp;
    logic [DATA_WIDTH-1:0]   s1_new;

    logic                    rd0_valid;
    logic [DATA_WIDTH-1:0]   rd0_data;

    logic                    wr_go;
    logic                    rd_go;
    logic                    clr_last;

    assign ready    = (state == IDLE);
    assign busy     = (state == CLEAR);
    assign wr_go    = wr_en && ready;
    assign rd_go    = rd_en && ready;
    assign clr_last = (clr_addr == {ADDR_WIDTH{1'b1}});

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_start) state_nxt = CLEAR;
            CLEAR:   if (clr_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sign-extended sum: a carry-out that disagrees with the sign bit means overflow.
    always_comb begin
        s1_sum   = {s1_old[DATA_WIDTH-1], s1_old} + {s1_data[DATA_WIDTH-1], s1_data};
        s1_clamp = s1_acc && (s1_sum[DATA_WIDTH] != s1_sum[DATA_WIDTH-1]);
        s1_new   = s1_data;
        if (s1_acc) begin
            if (s1_clamp) s1_new = s1_sum[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
            else          s1_new = s1_sum[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= (CLR_ON_RST != 0) ? CLEAR : IDLE;
            clr_addr  <= '0;
            ovf       <= 1'b0;
            s1_valid  <= 1'b0;
            s1_acc    <= 1'b0;
            s1_addr   <= '0;
            s1_data   <= '0;
            s1_old    <= '0;
            rd0_valid <= 1'b0;
            rd0_data  <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
            else                clr_addr <= '0;

            if (state == IDLE && state_nxt == CLEAR)       ovf <= 1'b0;
            else if (state == IDLE && s1_valid && s1_clamp) ovf <= 1'b1;

            // Stage 0: capture the op and its old value, forwarding the in-flight result.
            s1_valid <= wr_go;
            if (wr_go) begin
                s1_acc  <= wr_acc;
                s1_addr <= wr_addr;
                s1_data <= wr_data;
                s1_old  <= (s1_valid && s1_addr == wr_addr) ? s1_new : mem[wr_addr];
            end

            rd0_valid <= rd_go;
            if (rd_go)
                rd0_data <= (s1_valid && s1_addr == rd_addr) ? s1_new : mem[rd_addr];
        end
    end

    // Single write port; the sweep takes priority since it overwrites every entry anyway.
    always_ff @(posedge clk) begin
        if (state == CLEAR)  mem[clr_addr] <= '0;
        else if (s1_valid)   mem[s1_addr]  <= s1_new;
    end

    generate
        if (OUTPUT_REG != 0) begin : g_oreg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                end else begin
                    rd_valid <= rd0_valid;
                    if (rd0_valid) rd_data <= rd0_data;
                end
            end
        end else begin : g_noreg
            assign rd_valid = rd0_valid;
            assign rd_data  = rd0_data;
        end
    endgenerate

endmodule

// File: tb/tb_vq_accum_ram.sv
// Directed bench for vq_accum_ram (default parameters): reset sweep, overwrite/accumulate,
// forwarding, saturation and ovf, read-vs-write ordering, and dropped requests while clearing.
module tb_vq_accum_ram;

    localparam int DW = 24;
    localparam int AW = 8;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic          wr_acc;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          clr_start;
    logic          ready;
    logic          busy;
    logic          ovf;

    int compared = 0;
    int mismatched = 0;

    vq_accum_ram #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .OUTPUT_REG(0),
        .CLR_ON_RST(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .wr_acc(wr_acc),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .clr_start(clr_start),
        .ready(ready),
        .busy(busy),
        .ovf(ovf)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic acc, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_acc = acc; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic wr_rd_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [DW-1:0] exp);
        wr_en = 1'b1; wr_acc = 1'b0; wr_addr = a; wr_data = d;
        rd_en = 1'b1; rd_addr = a;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        int n;
        logic [DW-1:0] held;

        rst_n = 1'b0; wr_en = 1'b0; wr_acc = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0; clr_start = 1'b0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        // Reset sweep lasts exactly 2**AW cycles after release.
        rst_n = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < 1000);
        check("rst_sweep_len", 32'(n), 32'd256);
        check("post_sweep_ready", 32'(ready), 32'd1);
        rd_chk("clr_a0", 8'd0, 24'h0);
        rd_chk("clr_a127", 8'd127, 24'h0);
        rd_chk("clr_a255", 8'd255, 24'h0);

        // Overwrite then accumulate on consecutive cycles, read immediately.
        wr(1'b0, 8'd5, 24'h000010);
        wr(1'b1, 8'd5, 24'h000003);
        rd_chk("acc_a5", 8'd5, 24'h000013);
        tick();
        check("rd_valid_strobe", 32'(rd_valid), 32'd0);
        check("rd_data_hold", 32'(rd_data), 32'h000013);

        // Back-to-back accumulates exercise forwarding.
        wr(1'b1, 8'd9, 24'h000001);
        wr(1'b1, 8'd9, 24'h000002);
        wr(1'b1, 8'd9, 24'hFFFFFC);
        wr(1'b1, 8'd9, 24'h00000A);
        rd_chk("fwd_a9", 8'd9, 24'h000009);

        // Saturation at both ends.
        check("ovf_before", 32'(ovf), 32'd0);
        wr(1'b0, 8'd3, 24'h7FFFF0);
        wr(1'b1, 8'd3, 24'h000020);
        rd_chk("sat_max", 8'd3, 24'h7FFFFF);
        check("ovf_set", 32'(ovf), 32'd1);
        wr(1'b0, 8'd4, 24'h800005);
        wr(1'b1, 8'd4, 24'hFFFFF0);
        rd_chk("sat_min", 8'd4, 24'h800000);
        check("ovf_sticky", 32'(ovf), 32'd1);

        // Write then read next cycle; read alongside a write sees the previous value.
        wr(1'b0, 8'd7, 24'h00ABCD);
        rd_chk("raw_a7", 8'd7, 24'h00ABCD);
        wr_rd_chk("same_cyc_a7", 8'd7, 24'h123456, 24'h00ABCD);
        rd_chk("after_same_a7", 8'd7, 24'h123456);
        wr(1'b1, 8'd7, 24'h000001);
        tick();
        rd_chk("committed_a7", 8'd7, 24'h123457);

        // Op still in flight when the clear starts; requests during the sweep are dropped.
        wr(1'b0, 8'd10, 24'h000077);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        check("clr_busy", 32'(busy), 32'd1);
        check("clr_ready", 32'(ready), 32'd0);
        check("clr_ovf_cleared", 32'(ovf), 32'd0);
        wr_en = 1'b1; wr_acc = 1'b0; wr_addr = 8'd7; wr_data = 24'h000055;
        rd_en = 1'b1; rd_addr = 8'd7; clr_start = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            if (!busy) begin
                wr_en = 1'b0; rd_en = 1'b0; clr_start = 1'b0;
            end
            check("busy_no_rd_valid", 32'(rd_valid), 32'd0);
        end while (busy && n < 1000);
        wr_en = 1'b0; rd_en = 1'b0; clr_start = 1'b0;
        check("clr_sweep_len", 32'(n), 32'd256);
        tick();
        check("no_late_rd_valid", 32'(rd_valid), 32'd0);
        check("no_restart", 32'(busy), 32'd0);
        rd_chk("post_clr_a3", 8'd3, 24'h0);
        rd_chk("post_clr_a4", 8'd4, 24'h0);
        rd_chk("post_clr_a5", 8'd5, 24'h0);
        rd_chk("post_clr_a7", 8'd7, 24'h0);
        rd_chk("post_clr_a9", 8'd9, 24'h0);
        rd_chk("post_clr_a10", 8'd10, 24'h0);
        check("post_clr_ovf", 32'(ovf), 32'd0);

        // Negative-side accumulate without clamp leaves ovf clear.
        wr(1'b0, 8'd20, 24'hFFFFF0);
        wr(1'b1, 8'd20, 24'hFFFFF0);
        rd_chk("neg_acc_a20", 8'd20, 24'hFFFFE0);
        check("neg_acc_ovf", 32'(ovf), 32'd0);

        // Reset mid-operation restarts the sweep from address 0.
        wr(1'b0, 8'd30, 24'h000123);
        rst_n = 1'b0;
        #2;
        check("rst2_busy", 32'(busy), 32'd1);
        check("rst2_rd_data", 32'(rd_data), 32'd0);
        tick();
        rst_n = 1'b1;
        held = '0;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < 1000);
        check("rst2_sweep_len", 32'(n), 32'd256);
        rd_chk("rst2_a30", 8'd30, held);
        rd_chk("rst2_a20", 8'd20, 24'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
